// File: rtl/sideband_level_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sideband_level_monitor
// Description : Debounces synchronized sideband levels, keeps sticky change
//               status and serializes change events round-robin onto a
//               valid/ready port. Optional per-channel change counters are
//               enabled with SIDEBAND_EVT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sideband_level_monitor #(
    parameter int   NUM_CH          = 4,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter logic INIT_LEVEL      = 1'b1,
    localparam int  c_CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_CH-1:0]   level_in,
    output logic [NUM_CH-1:0]   stable_level,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [c_CH_W-1:0]   evt_ch,
    output logic                evt_level,
    output logic                evt_overrun,
    output logic [NUM_CH-1:0]   status,
    input  logic [NUM_CH-1:0]   status_clr,
    input  logic [NUM_CH-1:0]   irq_mask,
    output logic                irq
`ifdef SIDEBAND_EVT_CNT_EN
    ,
    output logic [16*NUM_CH-1:0] evt_count
`endif
);

    localparam int                c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0]        c_ST_EMPTY = 1'b0;
    localparam logic [0:0]        c_ST_FULL  = 1'b1;

    logic [NUM_CH-1:0] w_stable;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_overrun;
    logic [NUM_CH-1:0] w_status;
    logic [NUM_CH-1:0] w_accept;
    logic [NUM_CH-1:0] w_grant_oh;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              w_load;
    logic              w_any_pending;
    logic [c_CH_W-1:0] w_grant;
    logic [c_CH_W:0]   w_idx;
    logic [c_CH_W-1:0] r_rr_ptr;
    logic [c_CH_W-1:0] r_evt_ch;
    logic              r_evt_level;
    logic              r_evt_overrun;
    logic              r_irq;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_stb;
            logic               r_pend;
            logic               r_ovr;
            logic               r_sts;

            assign w_accept[i]   = (level_in[i] != r_stb) && (r_cnt == c_CNT_LAST);
            assign w_grant_oh[i] = w_load && (w_grant == c_CH_W'(i));
            assign w_stable[i]   = r_stb;
            assign w_pending[i]  = r_pend;
            assign w_overrun[i]  = r_ovr;
            assign w_status[i]   = r_sts;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_cnt <= '0;
                    r_stb <= INIT_LEVEL;
                end else if (level_in[i] == r_stb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_stb <= level_in[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            // A change accepted while this channel is being granted re-arms
            // pending without flagging overrun: the granted event is the old one.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_pend <= 1'b0;
                    r_ovr  <= 1'b0;
                end else if (w_accept[i]) begin
                    r_pend <= 1'b1;
                    r_ovr  <= r_pend & ~w_grant_oh[i];
                end else if (w_grant_oh[i]) begin
                    r_pend <= 1'b0;
                    r_ovr  <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_sts <= 1'b0;
                end else if (w_accept[i]) begin
                    r_sts <= 1'b1;
                end else if (status_clr[i]) begin
                    r_sts <= 1'b0;
                end
            end

`ifdef SIDEBAND_EVT_CNT_EN
            logic [15:0] r_evt_cnt;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_evt_cnt <= '0;
                end else if (w_accept[i]) begin
                    if (r_evt_cnt != 16'hFFFF) begin
                        r_evt_cnt <= r_evt_cnt + 16'd1;
                    end
                end else if (status_clr[i]) begin
                    r_evt_cnt <= '0;
                end
            end

            assign evt_count[16*i +: 16] = r_evt_cnt;
`endif
        end
    endgenerate

    // Scanning from the far end lets the lowest offset from rr_ptr win.
    always_comb begin
        w_grant       = '0;
        w_idx         = '0;
        w_any_pending = |w_pending;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (c_CH_W + 1)'(k);
            if (w_idx >= (c_CH_W + 1)'(NUM_CH)) begin
                w_idx = w_idx - (c_CH_W + 1)'(NUM_CH);
            end
            if (w_pending[w_idx[c_CH_W-1:0]]) begin
                w_grant = w_idx[c_CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_any_pending) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_FULL;
                end
            end
            c_ST_FULL: begin
                if (evt_ready) begin
                    if (w_any_pending) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_EMPTY;
                    end
                end
            end
            default: w_state_nxt = c_ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_evt_ch      <= '0;
            r_evt_level   <= 1'b0;
            r_evt_overrun <= 1'b0;
            r_rr_ptr      <= '0;
        end else if (w_load) begin
            r_evt_ch      <= w_grant;
            r_evt_level   <= w_stable[w_grant];
            r_evt_overrun <= w_overrun[w_grant];
            r_rr_ptr      <= (w_grant == c_CH_W'(NUM_CH - 1)) ? '0 : w_grant + c_CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_status & ~irq_mask);
        end
    end

    assign stable_level = w_stable;
    assign status       = w_status;
    assign evt_valid    = (r_state == c_ST_FULL);
    assign evt_ch       = r_evt_ch;
    assign evt_level    = r_evt_level;
    assign evt_overrun  = r_evt_overrun;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sideband_level_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sideband_level_monitor
// Description : Directed self-checking bench for sideband_level_monitor
//               (NUM_CH=4, DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sideband_level_monitor;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] level_in;
    logic [3:0] stable_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_level;
    logic       evt_overrun;
    logic [3:0] status;
    logic [3:0] status_clr;
    logic [3:0] irq_mask;
    logic       irq;
`ifdef SIDEBAND_EVT_CNT_EN
    logic [63:0] evt_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sideband_level_monitor #(
        .NUM_CH          (4),
        .DEBOUNCE_CYCLES (4),
        .INIT_LEVEL      (1'b1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .level_in     (level_in),
        .stable_level (stable_level),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .evt_level    (evt_level),
        .evt_overrun  (evt_overrun),
        .status       (status),
        .status_clr   (status_clr),
        .irq_mask     (irq_mask),
        .irq          (irq)
`ifdef SIDEBAND_EVT_CNT_EN
        ,
        .evt_count    (evt_count)
`endif
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn     = 1'b0;
        level_in   = 4'hF;
        evt_ready  = 1'b0;
        status_clr = 4'h0;
        irq_mask   = 4'h0;

        // Reset state
        tick(3);
        check("rst_stable", 32'(stable_level), 32'hF);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_status", 32'(status), 32'h0);
        check("rst_ch", 32'(evt_ch), 32'h0);
        check("rst_level", 32'(evt_level), 32'h0);
        check("rst_ovr", 32'(evt_overrun), 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("idle_valid", 32'(evt_valid), 32'h0);
        end
        check("idle_stable", 32'(stable_level), 32'hF);
        check("idle_irq", 32'(irq), 32'h0);

        // Single change on ch2
        evt_ready = 1'b1;
        level_in  = 4'hB;
        tick(3);
        check("ch2_early", 32'(stable_level), 32'hF);
        tick(1);
        check("ch2_stable", 32'(stable_level), 32'hB);
        check("ch2_status", 32'(status), 32'h4);
        check("ch2_novalid", 32'(evt_valid), 32'h0);
        tick(1);
        check("ch2_valid", 32'(evt_valid), 32'h1);
        check("ch2_ch", 32'(evt_ch), 32'h2);
        check("ch2_level", 32'(evt_level), 32'h0);
        check("ch2_ovr", 32'(evt_overrun), 32'h0);
        check("ch2_irq", 32'(irq), 32'h1);
        tick(1);
        check("ch2_drain", 32'(evt_valid), 32'h0);
        status_clr = 4'h4;
        tick(1);
        status_clr = 4'h0;
        check("clr_status", 32'(status), 32'h0);
        check("clr_irq_lag", 32'(irq), 32'h1);
        tick(1);
        check("clr_irq", 32'(irq), 32'h0);

        // Three-sample glitch on ch1
        level_in = 4'h9;
        tick(3);
        check("glitch_mid", 32'(stable_level), 32'hB);
        level_in = 4'hB;
        tick(3);
        check("glitch_stable", 32'(stable_level), 32'hB);
        check("glitch_valid", 32'(evt_valid), 32'h0);
        check("glitch_status", 32'(status), 32'h0);

        // Reset while an event is loaded
        evt_ready = 1'b0;
        level_in  = 4'hA;
        tick(5);
        check("pre_rst_valid", 32'(evt_valid), 32'h1);
        check("pre_rst_ch", 32'(evt_ch), 32'h0);
        resetn   = 1'b0;
        level_in = 4'hF;
        tick(1);
        check("midrst_valid", 32'(evt_valid), 32'h0);
        check("midrst_stable", 32'(stable_level), 32'hF);
        check("midrst_status", 32'(status), 32'h0);
        resetn = 1'b1;
        tick(6);
        check("postrst_valid", 32'(evt_valid), 32'h0);

        // Channels 0,1,3 change together, consumer stalled
        level_in = 4'h4;
        tick(4);
        check("multi_stable", 32'(stable_level), 32'h4);
        check("multi_novalid", 32'(evt_valid), 32'h0);
        tick(1);
        check("multi_ch0", 32'(evt_ch), 32'h0);
        check("multi_level0", 32'(evt_level), 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(evt_valid), 32'h1);
            check("stall_ch", 32'(evt_ch), 32'h0);
            tick(1);
        end
        check("stall_end_ch", 32'(evt_ch), 32'h0);
        evt_ready = 1'b1;
        tick(1);
        check("multi_ch1_valid", 32'(evt_valid), 32'h1);
        check("multi_ch1", 32'(evt_ch), 32'h1);
        tick(1);
        check("multi_ch3_valid", 32'(evt_valid), 32'h1);
        check("multi_ch3", 32'(evt_ch), 32'h3);
        check("multi_level3", 32'(evt_level), 32'h0);
        tick(1);
        check("multi_drain", 32'(evt_valid), 32'h0);
        check("multi_status", 32'(status), 32'hB);

        // Overrun: ch0 toggles twice behind a stalled ch3 event
        evt_ready = 1'b0;
        level_in  = 4'hC;
        tick(5);
        check("ovr_ch3", 32'(evt_ch), 32'h3);
        check("ovr_ch3_level", 32'(evt_level), 32'h1);
        level_in = 4'hD;
        tick(4);
        check("ovr_first", 32'(stable_level), 32'hD);
        check("ovr_hold_ch", 32'(evt_ch), 32'h3);
        level_in = 4'hC;
        tick(4);
        check("ovr_second", 32'(stable_level), 32'hC);
        check("ovr_hold_valid", 32'(evt_valid), 32'h1);
        evt_ready = 1'b1;
        tick(1);
        check("ovr_ch0", 32'(evt_ch), 32'h0);
        check("ovr_flag", 32'(evt_overrun), 32'h1);
        check("ovr_level", 32'(evt_level), 32'h0);
        tick(1);
        check("ovr_drain", 32'(evt_valid), 32'h0);

        // Clear collides with re-accept on ch2; masking
        irq_mask   = 4'h4;
        status_clr = 4'hF;
        tick(1);
        status_clr = 4'h0;
        check("s6_cleared", 32'(status), 32'h0);
        level_in = 4'h8;
        tick(4);
        check("s6_first", 32'(status), 32'h4);
        level_in = 4'hC;
        tick(3);
        status_clr = 4'h4;
        tick(1);
        status_clr = 4'h0;
        check("s6_stable", 32'(stable_level), 32'hC);
        check("s6_set_wins", 32'(status), 32'h4);
        tick(1);
        check("s6_masked_irq", 32'(irq), 32'h0);
        irq_mask = 4'h0;
        tick(1);
        check("s6_unmasked_irq", 32'(irq), 32'h1);
`ifdef SIDEBAND_EVT_CNT_EN
        check("s6_count2", 32'(evt_count[47:32]), 32'h2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
